// File: rtl/mem_load_unit.sv
// mem_load_unit: issues one word-aligned bus read per load, extracts and extends the addressed field, flags AdEL
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        load request handshake (ready only in IDLE)
//   req_addr/req_type/req_signed  byte address, size (00 word, 01 half, 1x byte), sign-extend select
//   dreq_valid/dreq_addr       word-aligned bus read request, held until daddr_ok
//   daddr_ok/ddata_ok/ddata    bus address accept, read data valid, read data word
//   resp_valid/resp_ready      result handshake (valid only in DONE)
//   resp_data/resp_adel        extended load result, misaligned-address flag (data forced to 0)
module mem_load_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_type,
    input  logic              req_signed,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    input  logic              daddr_ok,
    input  logic              ddata_ok,
    input  logic [31:0]       ddata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_adel
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        type_q, type_d;
    logic              signed_q, signed_d;
    logic [31:0]       data_q, data_d;
    logic              adel_q, adel_d;
    logic              req_ready_q, dreq_valid_q, resp_valid_q;
    logic              misaligned;
    logic [31:0]       shifted, loaded;
    logic [15:0]       half;
    logic [7:0]        lane_b;
    assign misaligned = (req_type == 2'b01) ? req_addr[0] : (req_type == 2'b00) ? |req_addr[1:0] : 1'b0;
    assign half       = addr_q[1] ? ddata[31:16] : ddata[15:0];
    assign shifted    = ddata >> {addr_q[1:0], 3'b000};
    assign lane_b     = shifted[7:0];
    assign loaded     = (type_q == 2'b00) ? ddata :
                        (type_q == 2'b01) ? {{16{signed_q & half[15]}}, half} :
                                            {{24{signed_q & lane_b[7]}}, lane_b};
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        type_d   = type_q;
        signed_d = signed_q;
        data_d   = data_q;
        adel_d   = adel_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d   = req_addr;
                type_d   = req_type;
                signed_d = req_signed;
                data_d   = 32'h0;
                adel_d   = misaligned;
                state_d  = misaligned ? DONE : REQ;
            end
            REQ: if (daddr_ok) begin
                data_d  = ddata_ok ? loaded : data_q;
                state_d = ddata_ok ? DONE : WAIT;
            end
            WAIT: if (ddata_ok) begin
                data_d  = loaded;
                state_d = DONE;
            end
            default: state_d = resp_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            type_q       <= 2'b00;
            signed_q     <= 1'b0;
            data_q       <= 32'h0;
            adel_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            dreq_valid_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            type_q       <= type_d;
            signed_q     <= signed_d;
            data_q       <= data_d;
            adel_q       <= adel_d;
            req_ready_q  <= state_d == IDLE;
            dreq_valid_q <= state_d == REQ;
            resp_valid_q <= state_d == DONE;
        end
    end
    assign req_ready  = req_ready_q;
    assign dreq_valid = dreq_valid_q;
    assign dreq_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign resp_adel  = adel_q;
endmodule
